// File: rtl/int_ctrl.sv
// Interrupt controller feeding CP0: synchronises raw IRQ lines, keeps edge/level
// pending state, arbitrates lowest-index-first and hands one request at a time to CP0.
module int_ctrl #(
  parameter int N_IRQ       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_src,
  input  logic             reg_we,
  input  logic [1:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  output logic             ir_in,
  output logic [4:0]       irq_id,
  input  logic             ack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] A_MASK    = 2'd0;
  localparam logic [1:0] A_EDGE    = 2'd1;
  localparam logic [1:0] A_PENDING = 2'd2;
  localparam logic [1:0] A_CAUSE   = 2'd3;

  state_t           r_state;
  logic [N_IRQ-1:0] r_sync [SYNC_STAGES];
  logic [N_IRQ-1:0] r_hist;
  logic [N_IRQ-1:0] r_mask;
  logic [N_IRQ-1:0] r_edge_cfg;
  logic [N_IRQ-1:0] r_pend_edge;
  logic [31:0]      r_rdata;
  logic             r_ir_in;
  logic [4:0]       r_irq_id;

  logic [N_IRQ-1:0] w_sync;
  logic [N_IRQ-1:0] w_edge;
  logic [N_IRQ-1:0] w_pending;
  logic [N_IRQ-1:0] w_elig;
  logic [N_IRQ-1:0] w_w1c;
  logic [N_IRQ-1:0] w_clr;
  logic [4:0]       w_win_id;
  logic             w_dispatch;
  logic [31:0]      w_cause;
  logic             w_unused_wdata;

  assign w_sync    = r_sync[SYNC_STAGES-1];
  assign w_edge    = w_sync & ~r_hist;
  // Level-type bits are a live view of the synchronised line; edge-type bits are latched.
  assign w_pending = (r_pend_edge & r_edge_cfg) | (w_sync & ~r_edge_cfg);
  assign w_elig    = w_pending & r_mask;
  assign w_w1c     = (reg_we && (reg_addr == A_PENDING)) ? reg_wdata[N_IRQ-1:0] : '0;
  assign w_dispatch = (r_state == S_IDLE) && (|w_elig);
  assign w_cause   = {(r_state != S_IDLE), 26'd0, r_irq_id};
  assign w_unused_wdata = ^reg_wdata;

  // Lowest-index eligible source wins; scanning downward leaves the smallest index last.
  always_comb begin
    w_win_id = 5'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      w_win_id = w_elig[i] ? 5'(i) : w_win_id;
    end
  end

  // Clear sources: software W1C plus the dispatch clear of the winning source.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      w_clr[i] = w_w1c[i] | (w_dispatch && (w_win_id == 5'(i)));
    end
  end

  // Synchronisers, configuration registers, edge pending state and read-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
      r_hist      <= '0;
      r_mask      <= '0;
      r_edge_cfg  <= '0;
      r_pend_edge <= '0;
      r_rdata     <= 32'd0;
    end else begin
      r_sync[0] <= irq_src;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
      r_hist <= w_sync;
      if (reg_we && (reg_addr == A_MASK)) begin
        r_mask <= reg_wdata[N_IRQ-1:0];
      end else begin
        r_mask <= r_mask;
      end
      if (reg_we && (reg_addr == A_EDGE)) begin
        r_edge_cfg <= reg_wdata[N_IRQ-1:0];
      end else begin
        r_edge_cfg <= r_edge_cfg;
      end
      // A new edge wins over any clear landing on the same edge.
      r_pend_edge <= ((r_pend_edge & ~w_clr) | w_edge) & r_edge_cfg;
      case (reg_addr)
        A_MASK:    r_rdata <= 32'(r_mask);
        A_EDGE:    r_rdata <= 32'(r_edge_cfg);
        A_PENDING: r_rdata <= 32'(w_pending);
        A_CAUSE:   r_rdata <= w_cause;
        default:   r_rdata <= 32'd0;
      endcase
    end
  end

  // Request FSM with registered ir_in pulse and latched source ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ir_in  <= 1'b0;
      r_irq_id <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_dispatch) begin
            r_state  <= S_REQ;
            r_ir_in  <= 1'b1;
            r_irq_id <= w_win_id;
          end else begin
            r_state  <= S_IDLE;
            r_ir_in  <= 1'b0;
          end
        end
        S_REQ: begin
          r_state <= S_WAIT;
          r_ir_in <= 1'b0;
        end
        S_WAIT: begin
          r_ir_in <= 1'b0;
          if (ack) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_WAIT;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ir_in <= 1'b0;
        end
      endcase
    end
  end

  assign reg_rdata = r_rdata;
  assign ir_in     = r_ir_in;
  assign irq_id    = r_irq_id;

endmodule
